// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Build option: IMEM_BOOT_CHECKSUM_EN adds the CHECK state (trailer checksum byte).
package imem_boot_pkg;

  localparam int BYTES_PER_WORD = 4;

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_t;
`endif

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream, control and instruction-memory write bus of the boot loader.
// master = host/testbench side, slave = loader side.
interface imem_boot_loader_if #(
  parameter int CNT_W = 7
);
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             imem_we;
  logic [31:0]      imem_waddr;
  logic [31:0]      imem_wdata;
  logic             cpu_stall;
  logic             done;
  logic             chk_err;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_stall, done, chk_err
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata, cpu_stall, done, chk_err
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer: first byte lands in [7:0], last in [31:24].
// byte_last flags that the next accepted byte completes a word; word_full is
// high from the cycle after the completing byte until the next byte or clear.
module imem_byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full,
  output logic        byte_last
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic             full_q, full_d;

  // Shift each byte in from the top so four shifts leave byte 0 at the bottom.
  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    full_d     = full_q;
    if (clr) begin
      byte_idx_d = '0;
      word_d     = '0;
      full_d     = 1'b0;
    end else if (byte_en) begin
      word_d     = {byte_data, word_q[31:8]};
      byte_idx_d = byte_idx_q + IDX_W'(1);
      full_d     = (byte_idx_q == LAST_IDX);
    end
  end

  // Packer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      word_q     <= '0;
      full_q     <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      full_q     <= full_d;
    end
  end

  assign word      = word_q;
  assign word_full = full_q;
  assign byte_last = (byte_idx_q == LAST_IDX);
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a byte stream, packs it into 32-bit words and writes
// them to instruction memory while holding the CPU stalled.
// Build option: IMEM_BOOT_CHECKSUM_EN enables the mod-256 trailer checksum.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input logic              clk,
  input logic              rst,
  imem_boot_loader_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] count_eff;
  logic [31:0]      cur_addr;
  logic             more_words;
  logic             hs;
  logic             byte_ready;
  logic             pk_clr, pk_en, pk_full, pk_last;
  logic [31:0]      pk_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             chk_err_q, chk_err_d;
`endif

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .byte_en   (pk_en),
    .byte_data (bus.byte_data),
    .word      (pk_word),
    .word_full (pk_full),
    .byte_last (pk_last)
  );

  // Out-of-range counts (0 or above DEPTH) load the whole memory.
  assign count_eff  = ((bus.word_count == '0) || (32'(bus.word_count) > 32'(DEPTH)))
                      ? CNT_W'(DEPTH) : bus.word_count;
  assign cur_addr   = 32'(idx_q) << 2;
  assign more_words = (32'(idx_q) + 32'd1) < 32'(count_q);
  assign hs         = bus.byte_valid && byte_ready;
  assign pk_en      = hs && (state_q == ST_RECV);

  // Next-state and per-state output decode.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pk_clr     = 1'b0;
    byte_ready = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_d      = sum_q;
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          count_d = count_eff;
          idx_d   = '0;
          pk_clr  = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        byte_ready = 1'b1;
        if (hs) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_d = sum_q + bus.byte_data;
`endif
          if (pk_last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        waddr_d = cur_addr;
        wdata_d = pk_word;
        if (more_words) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RECV;
        end else begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        if (hs) begin
          chk_err_d = (bus.byte_data != sum_q);
          state_d   = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state register; reset abandons any session in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  // The write bus shows the live word during WRITE and holds it afterwards.
  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = (state_q == ST_WRITE) && pk_full;
  assign bus.imem_waddr = (state_q == ST_WRITE) ? cur_addr : waddr_q;
  assign bus.imem_wdata = (state_q == ST_WRITE) ? pk_word : wdata_q;
  assign bus.cpu_stall  = (state_q != ST_DONE);
  assign bus.done       = (state_q == ST_DONE);
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign bus.chk_err    = chk_err_q;
`else
  assign bus.chk_err    = 1'b0;
`endif
endmodule
